// File: rtl/ee357_mcpu_pkg.sv
// Shared opcodes, PC-source encodings and the default datapath width for the ee357 multicycle CPU.
package ee357_mcpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] JAL   = 6'b000011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_TGT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_JR  = 2'b11;

endpackage

// File: rtl/ee357_mcpu_enreg.sv
// Width-parameterised register with load enable and asynchronous active-low reset to RST_VAL.
module ee357_mcpu_enreg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ee357_mcpu_fetch_unit.sv
// PC / IR / Target / MDR stage of the ee357 multicycle CPU, with memory address select.
// Optional cycle and instruction counters are built when EE357_MCPU_PERF_CNT_EN is defined.
module ee357_mcpu_fetch_unit
  import ee357_mcpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcw,
  input  logic            pcwc,
  input  logic            irw,
  input  logic            tw,
  input  logic            iord,
  input  logic [1:0]      pcs,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  output logic [5:0]      op,
  output logic [5:0]      func,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm_sext,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] mdr,
`ifdef EE357_MCPU_PERF_CNT_EN
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     instr_cnt,
`endif
  output logic            br_taken
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, target_q, mdr_q;
  logic            pc_en;

  // A BNE inverts the sense of the zero flag; every other opcode branches on zero.
  assign br_taken = pcwc & (alu_zero ^ (ir_q[31:26] == BNE));
  assign pc_en    = pcw | br_taken;

  always_comb begin
    pc_d = alu_result;
    unique case (pcs)
      PCS_ALU: pc_d = alu_result;
      PCS_TGT: pc_d = target_q;
      PCS_JMP: pc_d = {pc_q[XLEN-1:XLEN-4], ir_q[25:0], 2'b00};
      PCS_JR:  pc_d = rs_data;
      default: pc_d = alu_result;
    endcase
  end

  ee357_mcpu_enreg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk_i(clk), .rst_ni(rst), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
  );

  ee357_mcpu_enreg #(.W(XLEN), .RST_VAL('0)) u_ir_reg (
    .clk_i(clk), .rst_ni(rst), .en_i(irw), .d_i(mem_rdata), .q_o(ir_q)
  );

  ee357_mcpu_enreg #(.W(XLEN), .RST_VAL('0)) u_target_reg (
    .clk_i(clk), .rst_ni(rst), .en_i(tw), .d_i(alu_result), .q_o(target_q)
  );

  ee357_mcpu_enreg #(.W(XLEN), .RST_VAL('0)) u_mdr_reg (
    .clk_i(clk), .rst_ni(rst), .en_i(1'b1), .d_i(mem_rdata), .q_o(mdr_q)
  );

  assign mem_addr = iord ? alu_out : pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign target   = target_q;
  assign mdr      = mdr_q;
  assign op       = ir_q[31:26];
  assign func     = ir_q[5:0];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

`ifdef EE357_MCPU_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q;
    if (irw) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_ee357_mcpu_fetch_unit.sv
// Directed bench for ee357_mcpu_fetch_unit; counter checks build when EE357_MCPU_PERF_CNT_EN is defined.
module tb_ee357_mcpu_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pcw, pcwc, irw, tw, iord;
  logic [1:0]  pcs;
  logic [31:0] alu_result, alu_out, rs_data, mem_rdata;
  logic        alu_zero;
  logic [31:0] mem_addr, pc, ir, imm_sext, target, mdr;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic        br_taken;
`ifdef EE357_MCPU_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ee357_mcpu_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pcw(pcw), .pcwc(pcwc), .irw(irw), .tw(tw),
    .iord(iord), .pcs(pcs), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_out(alu_out), .rs_data(rs_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .op(op), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext), .target(target),
    .mdr(mdr),
`ifdef EE357_MCPU_PERF_CNT_EN
    .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt),
`endif
    .br_taken(br_taken)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcw = 0; pcwc = 0; irw = 0; tw = 0;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    irw = 1; mem_rdata = instr;
    tick();
    irw = 0;
  endtask

  task automatic load_target(input logic [31:0] val);
    tw = 1; alu_result = val;
    tick();
    tw = 0;
  endtask

  initial begin
    rst = 0; idle(); iord = 0; pcs = 2'b00; alu_zero = 0;
    alu_result = 0; alu_out = 0; rs_data = 0; mem_rdata = 0;

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_pc_held", pc, 32'h0);
    @(negedge clk);
    rst = 1;
    #1;
    check_eq("rel_pc", pc, 32'h0);
    check_eq("rel_ir", ir, 32'h0);
    check_eq("rel_op", {26'd0, op}, 32'h0);
    check_eq("rel_func", {26'd0, func}, 32'h0);
    check_eq("rel_target", target, 32'h0);

    // fetch: IR and PC load together from pre-edge values
    irw = 1; mem_rdata = 32'h8C220004; pcw = 1; pcs = 2'b00; alu_result = 32'd4;
    tick();
    idle();
    check_eq("fetch_ir", ir, 32'h8C220004);
    check_eq("fetch_op", {26'd0, op}, 32'h23);
    check_eq("fetch_pc", pc, 32'h4);
    check_eq("fetch_mdr", mdr, 32'h8C220004);
    check_eq("fields_rs_rt", {22'd0, rs, rt}, {22'd0, 5'd1, 5'd2});
    check_eq("imm_pos", imm_sext, 32'h4);

    // MDR is free-running; IR holds with irw low
    mem_rdata = 32'h0000_8001;
    tick();
    check_eq("mdr_free", mdr, 32'h0000_8001);
    check_eq("ir_hold", ir, 32'h8C220004);

    // address select
    iord = 0; alu_out = 32'h100;
    #1 check_eq("addr_pc", mem_addr, 32'h4);
    iord = 1;
    #1 check_eq("addr_alu", mem_addr, 32'h100);
    iord = 0;

    // BEQ: taken on zero
    load_ir(32'h1022FFFC);
    check_eq("imm_neg", imm_sext, 32'hFFFFFFFC);
    load_target(32'h40);
    check_eq("beq_target", target, 32'h40);
    pcwc = 1; pcs = 2'b01; alu_zero = 1;
    #1 check_eq("beq_taken", {31'd0, br_taken}, 32'd1);
    tick();
    pcwc = 0;
    check_eq("beq_pc", pc, 32'h40);
    load_target(32'h80);
    pcwc = 1; alu_zero = 0;
    #1 check_eq("beq_nt", {31'd0, br_taken}, 32'd0);
    tick();
    pcwc = 0;
    check_eq("beq_nt_pc", pc, 32'h40);

    // BNE: taken on non-zero
    load_ir(32'h14220005);
    check_eq("bne_op", {26'd0, op}, 32'h05);
    pcwc = 1; pcs = 2'b01; alu_zero = 0;
    #1 check_eq("bne_taken", {31'd0, br_taken}, 32'd1);
    tick();
    pcwc = 0;
    check_eq("bne_pc", pc, 32'h80);
    load_target(32'hC0);
    pcwc = 1; alu_zero = 1;
    #1 check_eq("bne_nt", {31'd0, br_taken}, 32'd0);
    tick();
    check_eq("bne_nt_pc", pc, 32'h80);
    // pcw overrides a failing condition
    pcw = 1;
    tick();
    idle();
    check_eq("pcw_wins", pc, 32'hC0);

    // jump: PC upper nibble kept, ir[25:0] shifted
    irw = 1; mem_rdata = 32'h08000010; pcw = 1; pcs = 2'b00; alu_result = 32'h10000004;
    tick();
    idle();
    check_eq("jmp_pre_pc", pc, 32'h10000004);
    check_eq("jmp_pre_ir", ir, 32'h08000010);
    pcw = 1; pcs = 2'b10;
    tick();
    idle();
    check_eq("jmp_pc", pc, 32'h10000040);

    // JR
    pcw = 1; pcs = 2'b11; rs_data = 32'hDEADBEE0;
    tick();
    idle();
    check_eq("jr_pc", pc, 32'hDEADBEE0);

    // wrap comes straight from alu_result
    pcw = 1; pcs = 2'b00; alu_result = 32'h0;
    tick();
    idle();
    check_eq("wrap_pc", pc, 32'h0);
    pcs = 2'b11; rs_data = 32'h1234;
    tick();
    check_eq("idle_hold", pc, 32'h0);

    // asynchronous reset between edges while pcw is active
    pcw = 1; pcs = 2'b11; rs_data = 32'h55;
    tick();
    check_eq("pre_rst_pc", pc, 32'h55);
    #2 rst = 0;
    #1;
    check_eq("async_pc", pc, 32'h0);
    check_eq("async_ir", ir, 32'h0);
    check_eq("async_tgt", target, 32'h0);
    @(negedge clk);
    idle();
    rst = 1;

`ifdef EE357_MCPU_PERF_CNT_EN
    @(negedge clk);
    rst = 0;
    #1;
    check_eq("cnt_rst_cyc", cyc_cnt, 32'd0);
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      irw = (i == 1 || i == 4 || i == 8);
      tick();
    end
    irw = 0;
    check_eq("cyc_cnt", cyc_cnt, 32'd10);
    check_eq("instr_cnt", instr_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
